// File: rtl/spi_arb_pkg.sv
// State encoding and shared constants for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_TRIG      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam int TIMEOUT_DEFAULT = 200000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active requester after last_grant,
// wrapping modulo R.
module rr_arbiter import spi_arb_pkg::*; #(
  parameter int R  = 4,
  parameter int IW = idx_width(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [R-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= R; off++) begin
      cand = IW'((int'(last_grant) + off) % R);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between R requesters with round-robin grants.
// IDLE: no transfer | GRANT: pick and latch config | TRIG: start pulse
// WAIT_LOW: master accepted? | WAIT_HIGH: master done? | DONE: ack + result
module spi_arbiter import spi_arb_pkg::*; #(
  parameter int R       = 4,
  parameter int N       = 1,
  parameter int C       = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           CLK_IN,
  input  logic           RST_N,
  input  logic [R-1:0]   req,
  input  logic [R*C-1:0] req_data,
  input  logic [R*N-1:0] req_target,
  input  logic [R-1:0]   req_cpol,
  input  logic [R-1:0]   req_cpha,
  output logic [R-1:0]   ack,
  output logic [C-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic [C-1:0]   spi_din,
  output logic [N-1:0]   spi_target,
  output logic           spi_cpol,
  output logic           spi_cpha,
  output logic           spi_trigger,
  input  logic [C-1:0]   spi_dout,
  input  logic           spi_valid
);

  localparam int          IW          = idx_width(R);
  localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [R-1:0]  grant_oh;
  logic [31:0]   wait_cnt;
  logic [R-1:0]  win_grant;
  logic [IW-1:0] win_idx;
  logic          win_valid;
  logic          timed_out;

  rr_arbiter #(.R(R), .IW(IW)) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (win_grant),
    .idx        (win_idx)
  );

  assign win_valid = |win_grant;
  assign timed_out = (wait_cnt == TIMEOUT_CNT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      ack         <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      spi_din     <= '0;
      spi_target  <= '0;
      spi_cpol    <= 1'b0;
      spi_cpha    <= 1'b0;
      spi_trigger <= 1'b0;
      last_grant  <= IW'(R - 1);
      grant_oh    <= '0;
      wait_cnt    <= '0;
    end else begin
      ack         <= '0;
      spi_trigger <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) state <= S_GRANT;
        end
        // A request that vanished between IDLE and GRANT simply returns to IDLE.
        S_GRANT: begin
          if (win_valid) begin
            spi_din     <= req_data[int'(win_idx)*C +: C];
            spi_target  <= req_target[int'(win_idx)*N +: N];
            spi_cpol    <= req_cpol[win_idx];
            spi_cpha    <= req_cpha[win_idx];
            last_grant  <= win_idx;
            grant_oh    <= win_grant;
            spi_trigger <= 1'b1;
            state       <= S_TRIG;
          end else begin
            state <= S_IDLE;
          end
        end
        S_TRIG: begin
          wait_cnt <= '0;
          state    <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          wait_cnt <= wait_cnt + 32'd1;
          if (timed_out) begin
            ack      <= grant_oh;
            rsp_data <= spi_dout;
            rsp_err  <= 1'b1;
            state    <= S_DONE;
          end else if (!spi_valid) begin
            state <= S_WAIT_HIGH;
          end
        end
        // A completion seen in the same cycle as the timeout counts as success.
        S_WAIT_HIGH: begin
          wait_cnt <= wait_cnt + 32'd1;
          if (spi_valid || timed_out) begin
            ack      <= grant_oh;
            rsp_data <= spi_dout;
            rsp_err  <= !spi_valid;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          spi_target <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: table of single transfers, directed
// corner sequences, and a randomized run against a round-robin scoreboard.
module tb_spi_arbiter;

  localparam int R  = 4;
  localparam int N  = 1;
  localparam int C  = 32;
  localparam int TO = 50;

  logic           CLK_IN = 1'b0;
  logic           RST_N  = 1'b0;
  logic [R-1:0]   req;
  logic [R*C-1:0] req_data;
  logic [R*N-1:0] req_target;
  logic [R-1:0]   req_cpol;
  logic [R-1:0]   req_cpha;
  logic [R-1:0]   ack;
  logic [C-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;
  logic [C-1:0]   spi_din;
  logic [N-1:0]   spi_target;
  logic           spi_cpol;
  logic           spi_cpha;
  logic           spi_trigger;
  logic [C-1:0]   spi_dout  = '0;
  logic           spi_valid = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  spi_arbiter #(.R(R), .N(N), .C(C), .TIMEOUT(TO)) dut (
    .CLK_IN      (CLK_IN),
    .RST_N       (RST_N),
    .req         (req),
    .req_data    (req_data),
    .req_target  (req_target),
    .req_cpol    (req_cpol),
    .req_cpha    (req_cpha),
    .ack         (ack),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .spi_din     (spi_din),
    .spi_target  (spi_target),
    .spi_cpol    (spi_cpol),
    .spi_cpha    (spi_cpha),
    .spi_trigger (spi_trigger),
    .spi_dout    (spi_dout),
    .spi_valid   (spi_valid)
  );

  always #5 CLK_IN = ~CLK_IN;
  always @(posedge CLK_IN) cyc++;

  // Loopback master: drops valid after a trigger, raises it L cycles later
  // with the word it was given; a hung master never completes.
  bit m_stub = 1'b0;
  bit m_rand = 1'b0;
  int m_lat  = 4;
  int m_cnt  = 0;
  bit m_active = 1'b0;
  bit m_hang   = 1'b0;
  int rise_cyc = 0;

  always @(posedge CLK_IN) begin
    #2;
    if (spi_trigger) begin
      spi_valid = 1'b0;
      m_active  = 1'b1;
      m_hang    = m_stub;
      m_cnt     = m_rand ? int'($urandom_range(7, 2)) : m_lat;
    end else if (m_active && !m_hang) begin
      m_cnt--;
      if (m_cnt == 0) begin
        spi_valid = 1'b1;
        spi_dout  = spi_din;
        m_active  = 1'b0;
        rise_cyc  = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  logic [31:0] r_data [R];
  logic        r_tgt  [R];
  logic        r_cpol [R];
  logic        r_cpha [R];

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        tgt;
    logic        cpol;
    logic        cpha;
    logic [3:0]  exp_ack;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < R; i++) begin
      req_data[i*C +: C] = r_data[i];
      req_target[i]      = r_tgt[i];
      req_cpol[i]        = r_cpol[i];
      req_cpha[i]        = r_cpha[i];
    end
  endtask

  task automatic wait_trig(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK_IN);
      if (spi_trigger) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int limit, output int waited);
    waited = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge CLK_IN);
      if (ack != '0) begin
        waited = k;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge CLK_IN);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK_IN);
    RST_N = 1'b1;
    @(negedge CLK_IN);
  endtask

  initial begin
    int          lat, w, trig_c, quiet, n_acks;
    logic [1:0]  win, cand, m_last;
    logic        found, in_flight, abort;
    logic [3:0]  acc;
    logic [31:0] exp_d;

    tbl[0] = '{4'b0001, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hA5A5_0F0F};
    tbl[1] = '{4'b0100, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 4'b0100, 32'h3234_5678};
    tbl[2] = '{4'b1011, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 4'b1000, 32'hEEAD_BEEF};
    tbl[3] = '{4'b1011, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 4'b0001, 32'h0000_0000};
    tbl[4] = '{4'b1010, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 4'b0010, 32'hEFFF_FFFF};
    tbl[5] = '{4'b1001, 32'h0F0F_F0F0, 1'b1, 1'b0, 1'b1, 4'b1000, 32'h3F0F_F0F0};
    tbl[6] = '{4'b0110, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1, 4'b0010, 32'h4555_AAAA};
    tbl[7] = '{4'b0001, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 4'b0001, 32'h8000_0001};

    req = '0;
    for (int i = 0; i < R; i++) begin
      r_data[i] = '0; r_tgt[i] = 1'b0; r_cpol[i] = 1'b0; r_cpha[i] = 1'b0;
    end
    drive();

    repeat (3) @(negedge CLK_IN);
    chk("rst_ack",     64'(ack), 64'(0));
    chk("rst_busy",    64'(busy), 64'(0));
    chk("rst_rsp",     64'(rsp_data), 64'(0));
    chk("rst_err",     64'(rsp_err), 64'(0));
    chk("rst_din",     64'(spi_din), 64'(0));
    chk("rst_target",  64'(spi_target), 64'(0));
    chk("rst_cpol",    64'(spi_cpol), 64'(0));
    chk("rst_cpha",    64'(spi_cpha), 64'(0));
    chk("rst_trigger", 64'(spi_trigger), 64'(0));
    RST_N = 1'b1;
    @(negedge CLK_IN);

    // Table of single transactions starting from the reset grant pointer.
    m_lat = 4;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < R; i++) begin
        r_data[i] = tbl[t].data ^ (32'(i) << 28);
        r_tgt[i]  = tbl[t].tgt;
        r_cpol[i] = tbl[t].cpol;
        r_cpha[i] = tbl[t].cpha;
      end
      drive();
      req = tbl[t].req;
      wait_trig(lat);
      chk("tbl_trig_lat", 64'(lat), 64'(2));
      chk("tbl_spi_din",  64'(spi_din), 64'(tbl[t].exp_rsp));
      chk("tbl_spi_tgt",  64'(spi_target), 64'(tbl[t].tgt));
      chk("tbl_spi_cpol", 64'(spi_cpol), 64'(tbl[t].cpol));
      chk("tbl_spi_cpha", 64'(spi_cpha), 64'(tbl[t].cpha));
      wait_ack(40, w);
      chk("tbl_ack",      64'(ack), 64'(tbl[t].exp_ack));
      chk("tbl_rsp",      64'(rsp_data), 64'(tbl[t].exp_rsp));
      chk("tbl_err",      64'(rsp_err), 64'(0));
      chk("tbl_ack_lat",  64'(cyc - rise_cyc), 64'(1));
      req = '0;
      @(negedge CLK_IN);
      chk("tbl_ack_pulse", 64'(ack), 64'(0));
      chk("tbl_idle_busy", 64'(busy), 64'(0));
      chk("tbl_idle_tgt",  64'(spi_target), 64'(0));
      chk("tbl_rsp_held",  64'(rsp_data), 64'(tbl[t].exp_rsp));
    end

    // All four held high: fair rotation 0,1,2,3,0 with one ack each.
    reset_dut();
    for (int i = 0; i < R; i++) r_data[i] = 32'hC0DE_0000 + 32'(i);
    drive();
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, w);
      chk("s2_ack_seen",  64'(w > 0), 64'(1));
      chk("s2_order",     64'(ack), 64'(4'b0001 << (k % 4)));
      chk("s2_rsp",       64'(rsp_data), 64'(32'hC0DE_0000 + 32'(k % 4)));
      @(negedge CLK_IN);
      chk("s2_one_pulse", 64'(ack), 64'(0));
    end
    req = '0;
    repeat (2) @(negedge CLK_IN);

    // Requester 2 changes its word while the transfer is in flight.
    m_lat = 6;
    r_data[2] = 32'hCAFE_0002;
    drive();
    req = 4'b0100;
    wait_trig(lat);
    repeat (3) @(negedge CLK_IN);
    r_data[2] = 32'h0BAD_0BAD;
    drive();
    @(negedge CLK_IN);
    chk("s3_din_hold", 64'(spi_din), 64'(32'hCAFE_0002));
    wait_ack(20, w);
    chk("s3_ack", 64'(ack), 64'(4'b0100));
    chk("s3_rsp", 64'(rsp_data), 64'(32'hCAFE_0002));
    req = '0;
    @(negedge CLK_IN);

    // Master never completes: timeout ack 52 cycles after the trigger.
    m_stub = 1'b1;
    r_data[0] = 32'h1111_2222;
    drive();
    req = 4'b0001;
    wait_trig(lat);
    trig_c = cyc;
    wait_ack(80, w);
    chk("s4_timeout_lat", 64'(cyc - trig_c), 64'(52));
    chk("s4_ack",         64'(ack), 64'(4'b0001));
    chk("s4_err",         64'(rsp_err), 64'(1));
    req = '0;
    m_stub = 1'b0;
    @(negedge CLK_IN);
    chk("s4_err_held",    64'(rsp_err), 64'(1));
    @(negedge CLK_IN);

    // Reset in WAIT_HIGH abandons the transfer; pointer returns to requester 0.
    r_data[2] = 32'h5A5A_0005;
    drive();
    req = 4'b0100;
    wait_trig(lat);
    repeat (3) @(negedge CLK_IN);
    RST_N = 1'b0;
    #1;
    chk("s5_busy",    64'(busy), 64'(0));
    chk("s5_ack",     64'(ack), 64'(0));
    chk("s5_target",  64'(spi_target), 64'(0));
    chk("s5_rsp_rst", 64'(rsp_data), 64'(0));
    req = '0;
    @(negedge CLK_IN);
    RST_N = 1'b1;
    acc = '0;
    repeat (12) begin
      @(negedge CLK_IN);
      acc |= ack;
    end
    chk("s5_no_ack", 64'(acc), 64'(0));
    for (int i = 0; i < R; i++) r_data[i] = 32'h7700_0000 + 32'(i);
    drive();
    req = 4'hF;
    wait_ack(40, w);
    chk("s5_next_ack", 64'(ack), 64'(4'b0001));
    chk("s5_next_rsp", 64'(rsp_data), 64'(32'h7700_0000));
    chk("s5_next_err", 64'(rsp_err), 64'(0));
    req = '0;
    @(negedge CLK_IN);

    // Randomized traffic against a round-robin scoreboard.
    reset_dut();
    m_rand    = 1'b1;
    m_last    = 2'd3;
    in_flight = 1'b0;
    abort     = 1'b0;
    exp_d     = '0;
    win       = '0;
    quiet     = 0;
    n_acks    = 0;
    for (int c = 0; c < 3000 && !abort; c++) begin
      @(negedge CLK_IN);
      if (spi_trigger) begin
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= R; off++) begin
          cand = m_last + 2'(off);
          if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        chk("rnd_grant_has_req", 64'(found), 64'(1));
        chk("rnd_no_overlap",    64'(in_flight), 64'(0));
        exp_d     = r_data[win];
        m_last    = win;
        in_flight = 1'b1;
        chk("rnd_din",  64'(spi_din), 64'(r_data[win]));
        chk("rnd_tgt",  64'(spi_target), 64'(r_tgt[win]));
        chk("rnd_cpol", 64'(spi_cpol), 64'(r_cpol[win]));
        chk("rnd_cpha", 64'(spi_cpha), 64'(r_cpha[win]));
      end
      if (ack != '0) begin
        chk("rnd_ack_expected", 64'(in_flight), 64'(1));
        chk("rnd_ack",          64'(ack), 64'(4'b0001 << win));
        chk("rnd_rsp",          64'(rsp_data), 64'(exp_d));
        chk("rnd_err",          64'(rsp_err), 64'(0));
        in_flight = 1'b0;
        n_acks++;
        quiet = 0;
        if ($urandom_range(1, 0) == 1) begin
          req[win] = 1'b0;
        end else begin
          r_data[win] = $urandom;
          r_tgt[win]  = 1'($urandom_range(1, 0));
        end
      end
      if (!busy) chk("rnd_idle_tgt", 64'(spi_target), 64'(0));
      for (int i = 0; i < R; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3, 0) == 0) begin
            r_data[i] = $urandom;
            r_tgt[i]  = 1'($urandom_range(1, 0));
            r_cpol[i] = 1'($urandom_range(1, 0));
            r_cpha[i] = 1'($urandom_range(1, 0));
            req[i]    = 1'b1;
          end
        end else if ($urandom_range(7, 0) == 0) begin
          r_data[i] = $urandom;
          r_cpol[i] = 1'($urandom_range(1, 0));
          r_cpha[i] = 1'($urandom_range(1, 0));
        end
      end
      drive();
      if (req != '0) quiet++;
      if (quiet > 200) begin
        chk("rnd_watchdog", 64'(quiet), 64'(0));
        abort = 1'b1;
      end
    end
    chk("rnd_progress", 64'(n_acks > 100), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
